// File: rtl/ram_march_bist.sv
// ram_march_bist: March C- self-test controller for a single-port synchronous RAM.
//
// Runs M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0)
// and M5 up(r0) over the whole address space. It then reports pass/fail and the
// first failing address and march element.
//
// Optional feature (macro RAM_BIST_DIAG_EN):
//   defined   - a mismatch does not stop the run; err_count counts every
//               mismatching compare and saturates at 255.
//   undefined - the run stops on the first mismatch; err_count is tied to 0.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       begin a test (only accepted in IDLE or DONE)
//   busy        test in progress
//   done        test finished (level, held until the next accepted start)
//   pass        1 = no mismatch; valid while done=1
//   fail_addr   address of the first mismatch (0 if none)
//   fail_elem   march element 0-5 of the first mismatch (0 if none)
//   err_count   saturating mismatch count
//   mem_we, mem_addr, mem_wdata  RAM write enable, address and write data
//   mem_rdata   RAM read data, 1-cycle latency

module ram_march_bist #(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [addr_width-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [7:0]            err_count,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    input  logic [data_width-1:0] mem_rdata
);

    localparam logic [addr_width-1:0] addr_first = '0;
    localparam logic [addr_width-1:0] addr_last  = '1;
    localparam logic [2:0]            elem_last  = 3'd5;

`ifdef RAM_BIST_DIAG_EN
    localparam bit stop_on_fail = 1'b0;
`else
    localparam bit stop_on_fail = 1'b1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_RD,
        S_WCHK,
        S_CHK,
        S_DONE
    } state_t;

    // Elements 3 and 4 walk the address space downwards.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    // Value each element expects to read back.
    function automatic logic [data_width-1:0] elem_read_val(input logic [2:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? '1 : '0;
    endfunction

    // Value each element writes (M0 writes background 0).
    function automatic logic [data_width-1:0] elem_write_val(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? '1 : '0;
    endfunction

    state_t                  state_q, state_d;
    logic [2:0]              elem_q, elem_d;
    logic [addr_width-1:0]   addr_d;
    logic                    err_seen_q, err_seen_d;
    logic                    pass_d;
    logic [addr_width-1:0]   fail_addr_d;
    logic [2:0]              fail_elem_d;
    logic                    busy_d, done_d, mem_we_d;
    logic [data_width-1:0]   mem_wdata_d;
    logic                    compare_c, mismatch_c, at_last_c;
    logic [2:0]              elem_nxt_c;
`ifdef RAM_BIST_DIAG_EN
    logic [7:0]              err_cnt_q, err_cnt_d;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_q     <= 3'd0;
            mem_addr   <= '0;
            err_seen_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= 3'd0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            elem_q     <= elem_d;
            mem_addr   <= addr_d;
            err_seen_q <= err_seen_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            fail_addr  <= fail_addr_d;
            fail_elem  <= fail_elem_d;
            mem_we     <= mem_we_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

`ifdef RAM_BIST_DIAG_EN
    // Saturating mismatch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = mem_addr;
        err_seen_d  = err_seen_q;
        pass_d      = pass;
        fail_addr_d = fail_addr;
        fail_elem_d = fail_elem;
`ifdef RAM_BIST_DIAG_EN
        err_cnt_d   = err_cnt_q;
`endif

        compare_c  = (state_q == S_WCHK) || (state_q == S_CHK);
        mismatch_c = compare_c && (mem_rdata != elem_read_val(elem_q));
        at_last_c  = elem_down(elem_q) ? (mem_addr == addr_first)
                                       : (mem_addr == addr_last);
        elem_nxt_c = elem_q + 3'd1;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_WR0;
                    elem_d      = 3'd0;
                    addr_d      = addr_first;
                    err_seen_d  = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = 3'd0;
`ifdef RAM_BIST_DIAG_EN
                    err_cnt_d   = 8'd0;
`endif
                end
            end

            S_WR0: begin
                if (mem_addr == addr_last) begin
                    state_d = S_RD;
                    elem_d  = 3'd1;
                    addr_d  = addr_first;
                end else begin
                    addr_d = mem_addr + 1'b1;
                end
            end

            S_RD: begin
                state_d = (elem_q == elem_last) ? S_CHK : S_WCHK;
            end

            S_WCHK, S_CHK: begin
                // Only the first mismatch is recorded.
                if (mismatch_c) begin
                    if (!err_seen_q) begin
                        fail_addr_d = mem_addr;
                        fail_elem_d = elem_q;
                    end
                    err_seen_d = 1'b1;
`ifdef RAM_BIST_DIAG_EN
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
`endif
                end

                if (mismatch_c && stop_on_fail) begin
                    state_d = S_DONE;
                    pass_d  = 1'b0;
                end else if (at_last_c) begin
                    if (elem_q == elem_last) begin
                        state_d = S_DONE;
                        pass_d  = !(err_seen_q || mismatch_c);
                    end else begin
                        state_d = S_RD;
                        elem_d  = elem_nxt_c;
                        addr_d  = elem_down(elem_nxt_c) ? addr_last : addr_first;
                    end
                end else begin
                    state_d = S_RD;
                    addr_d  = elem_down(elem_q) ? (mem_addr - 1'b1) : (mem_addr + 1'b1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are valid in that state.
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        mem_we_d    = (state_d == S_WR0) || (state_d == S_WCHK);
        mem_wdata_d = (state_d == S_WCHK) ? elem_write_val(elem_d) : '0;
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Testbench for ram_march_bist: faulty-RAM model plus a March C- reference model.
module tb_ram_march_bist;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned D  = 16;

`ifdef RAM_BIST_DIAG_EN
    localparam bit diag = 1'b1;
`else
    localparam bit diag = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [7:0]    err_count;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    ram_march_bist #(.data_width(DW), .addr_width(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .err_count (err_count),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with per-address stuck-at-0 / stuck-at-1 bit masks.
    logic [DW-1:0] ram [D];
    logic [DW-1:0] sa0 [D];
    logic [DW-1:0] sa1 [D];

    function automatic logic [DW-1:0] flt(input int a, input logic [DW-1:0] v);
        return (v & ~sa0[a]) | sa1[a];
    endfunction

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= flt(int'(mem_addr), mem_wdata);
        else        mem_rdata     <= flt(int'(mem_addr), ram[mem_addr]);
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_faults();
        for (int i = 0; i < D; i++) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
    endtask

    // Reference: run March C- on an array, one cycle per write, two per read+compare.
    task automatic model(output int cyc, output bit pss, output int fa, output int fe, output int ec);
        logic [DW-1:0] m [D];
        logic [DW-1:0] rv, ex;
        bit stop, seen;
        int a;
        cyc = 0; ec = 0; fa = 0; fe = 0; seen = 0; stop = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < D; k++) begin
                if (!stop) begin
                    a = (e == 3 || e == 4) ? (D - 1 - k) : k;
                    if (e == 0) begin
                        m[a] = flt(a, 8'h00);
                        cyc  = cyc + 1;
                    end else begin
                        rv  = flt(a, m[a]);
                        ex  = (e == 2 || e == 4) ? 8'hFF : 8'h00;
                        cyc = cyc + 2;
                        if (e != 5) m[a] = flt(a, (e == 1 || e == 3) ? 8'hFF : 8'h00);
                        if (rv !== ex) begin
                            if (!seen) begin
                                fa = a;
                                fe = e;
                            end
                            seen = 1;
                            if (ec < 255) ec = ec + 1;
                            if (!diag) stop = 1;
                        end
                    end
                end
            end
        end
        pss = !seen;
        if (!diag) ec = 0;
    endtask

    // Pulse start, count busy cycles (optionally poke start or reset mid-run), check results.
    task automatic run(input string tag, input int p1, input int p2, input int abort_at);
        int cyc, mc, fa, fe, ec;
        bit pss;
        model(mc, pss, fa, fe, ec);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            cyc = cyc + 1;
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, ".abort_busy"}, 32'(busy), 32'd0);
                chk({tag, ".abort_done"}, 32'(done), 32'd0);
                chk({tag, ".abort_pass"}, 32'(pass), 32'd0);
                chk({tag, ".abort_we"},   32'(mem_we), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            start = (cyc == p1) || (cyc == p2);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ".cycles"},    32'(cyc),       32'(mc));
        chk({tag, ".done"},      32'(done),      32'd1);
        chk({tag, ".pass"},      32'(pass),      32'(pss));
        chk({tag, ".fail_addr"}, 32'(fail_addr), 32'(fa));
        chk({tag, ".fail_elem"}, 32'(fail_elem), 32'(fe));
        chk({tag, ".err_count"}, 32'(err_count), 32'(ec));
        chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
    endtask

    initial begin
        int cyc;
        int nf, a, b;
        rst_n = 1'b0;
        start = 1'b0;
        clear_faults();
        repeat (2) @(negedge clk);
        chk("rst.busy",      32'(busy),      32'd0);
        chk("rst.done",      32'(done),      32'd0);
        chk("rst.pass",      32'(pass),      32'd0);
        chk("rst.fail_addr", 32'(fail_addr), 32'd0);
        chk("rst.fail_elem", 32'(fail_elem), 32'd0);
        chk("rst.err_count", 32'(err_count), 32'd0);
        chk("rst.mem_we",    32'(mem_we),    32'd0);
        chk("rst.mem_addr",  32'(mem_addr),  32'd0);
        chk("rst.mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("clean", -1, -1, -1);

        sa0[5] = 8'h08;
        run("a5b3sa0", -1, -1, -1);
        clear_faults();

        sa1[15] = 8'h01;
        run("a15b0sa1", -1, -1, -1);
        clear_faults();

        run("ignore_start", 10, 100, -1);

        // start held while done restarts at once
        start = 1'b1;
        @(negedge clk);
        chk("hold.done", 32'(done), 32'd0);
        chk("hold.busy", 32'(busy), 32'd1);
        start = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 2000) begin
            cyc = cyc + 1;
            @(negedge clk);
        end
        chk("hold.cycles", 32'(cyc),  32'd176);
        chk("hold.pass",   32'(pass), 32'd1);

        run("abort", -1, -1, 40);
        chk("post_abort.busy", 32'(busy), 32'd0);
        chk("post_abort.done", 32'(done), 32'd0);
        run("after_abort", -1, -1, -1);

        sa0[5]  = 8'h08;
        sa1[15] = 8'h01;
        run("combined", -1, -1, -1);
        clear_faults();

        for (int it = 0; it < 8; it++) begin
            clear_faults();
            nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++) begin
                a = $urandom_range(0, D - 1);
                b = $urandom_range(0, DW - 1);
                if ($urandom_range(0, 1) == 0) sa0[a][b] = 1'b1;
                else                           sa1[a][b] = 1'b1;
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run($sformatf("rand%0d", it), -1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
